// File: rtl/alu16_pkg.sv
// alu16_pkg: shared definitions for the 16-bit ALU and its sequencing controller.
//   alu_func_e   : ALU op codes (ADD=0 .. NOP=16, CMP=17), FUNC_LAST = 17
//   FLAG_*       : bit positions inside the 6-bit flags word
//   flag_mask()  : flags written back by a given op
//   is_muldiv()  : ops that use the long MUL/DIV/MOD latency
//   ctrl_state_e : controller FSM states
package alu16_pkg;

    typedef enum logic [4:0] {
        FN_ADD  = 5'd0,
        FN_SUB  = 5'd1,
        FN_MUL  = 5'd2,
        FN_DIV  = 5'd3,
        FN_MOD  = 5'd4,
        FN_MVN  = 5'd5,
        FN_OR   = 5'd6,
        FN_AND  = 5'd7,
        FN_ORN  = 5'd8,
        FN_ANDN = 5'd9,
        FN_EOR  = 5'd10,
        FN_EON  = 5'd11,
        FN_REV  = 5'd12,
        FN_LSL  = 5'd13,
        FN_LSR  = 5'd14,
        FN_ASR  = 5'd15,
        FN_NOP  = 5'd16,
        FN_CMP  = 5'd17
    } alu_func_e;

    localparam logic [4:0] FUNC_LAST = 5'd17;

    localparam int unsigned FLAG_ZF  = 5;
    localparam int unsigned FLAG_CF4 = 4;
    localparam int unsigned FLAG_CF3 = 3;
    localparam int unsigned FLAG_PF  = 2;
    localparam int unsigned FLAG_GF  = 1;
    localparam int unsigned FLAG_LF  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } ctrl_state_e;

    // Flags an op is allowed to update; all other bits keep their value.
    function automatic logic [5:0] flag_mask(input logic [4:0] func);
        logic [5:0] m;
        m = '0;
        if (func <= FN_DIV) begin
            m[FLAG_CF4] = 1'b1;
        end else if (func >= FN_LSL && func <= FN_ASR) begin
            m[FLAG_CF3] = 1'b1;
        end else if (func == FN_CMP) begin
            m[FLAG_ZF] = 1'b1;
            m[FLAG_PF] = 1'b1;
            m[FLAG_GF] = 1'b1;
            m[FLAG_LF] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic is_muldiv(input logic [4:0] func);
        return (func == FN_MUL) || (func == FN_DIV) || (func == FN_MOD);
    endfunction

endpackage

// File: rtl/alu16_ctrl.sv
// alu16_ctrl: sequencing controller for the combinational 16-bit ALU.
// Accepts one request at a time, drives the ALU for the op latency, captures
// result and flags, and presents a response until it is accepted.
//
// Parameters:
//   MULDIV_WAIT  EXEC cycles for MUL/DIV/MOD (>= 1)
// Optional feature:
//   ALU16_CTRL_DIVZERO_TRAP_EN  DIV/MOD with req_b == 0 responds immediately
//                               with rsp_y = FFFF, rsp_err = 1, no EXEC.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_func, req_a, req_b      op code and operands
//   flags_clr                   synchronous clear of the flags register
//   alu_a, alu_b, alu_func      registered operands / func to the ALU (NOP outside EXEC)
//   alu_flagsin                 current flags to the ALU
//   alu_y, alu_flagsout         ALU result and flags
//   rsp_valid/rsp_ready         response handshake
//   rsp_y, rsp_err              captured result, error indication
//   flags_q                     architectural flags register
module alu16_ctrl
    import alu16_pkg::*;
#(
    parameter int unsigned MULDIV_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_func,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic        flags_clr,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_func,
    output logic [5:0]  alu_flagsin,
    input  logic [15:0] alu_y,
    input  logic [5:0]  alu_flagsout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_y,
    output logic        rsp_err,
    output logic [5:0]  flags_q
);

    localparam int unsigned CNT_W = $clog2(MULDIV_WAIT + 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       func_q;
    logic             accept;
    logic             illegal;
    logic             trap;
    logic             capture;
    logic [5:0]       mask;

    assign accept  = (state_q == ST_IDLE) && req_valid;
    assign illegal = (req_func > FUNC_LAST);
    assign capture = (state_q == ST_EXEC) && (cnt_q == CNT_W'(1));
    assign mask    = flag_mask(func_q);

`ifdef ALU16_CTRL_DIVZERO_TRAP_EN
    assign trap = !illegal && ((req_func == FN_DIV) || (req_func == FN_MOD)) && (req_b == '0);
`else
    assign trap = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = (illegal || trap) ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        alu_func  = (state_q == ST_EXEC) ? func_q : FN_NOP;
    end

    assign alu_flagsin = flags_q;

    // Operand, counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            func_q  <= FN_NOP;
            cnt_q   <= '0;
            rsp_y   <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (accept) begin
                alu_a  <= req_a;
                alu_b  <= req_b;
                func_q <= req_func;
                cnt_q  <= is_muldiv(req_func) ? CNT_W'(MULDIV_WAIT) : CNT_W'(1);
                if (illegal) begin
                    rsp_y   <= '0;
                    rsp_err <= 1'b1;
                end else if (trap) begin
                    rsp_y   <= '1;
                    rsp_err <= 1'b1;
                end
            end
            if (state_q == ST_EXEC) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (capture) begin
                rsp_y   <= alu_y;
                rsp_err <= 1'b0;
            end
        end
    end

    // Flags register: a clear takes priority over a same-edge merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (flags_clr) begin
            flags_q <= '0;
        end else if (capture) begin
            flags_q <= (flags_q & ~mask) | (alu_flagsout & mask);
        end
    end

endmodule

// File: tb/tb_alu16_ctrl.sv
// tb_alu16_ctrl: self-checking bench for alu16_ctrl.
// A behavioural ALU stands in for alu16; a transaction-level reference model
// predicts every controller output, and a negedge compare process checks the
// DUT each cycle. Directed sequences pin the model with literal expectations,
// then randomized traffic runs against the model.
module tb_alu16_ctrl;

    localparam int unsigned W = 4;

`ifdef ALU16_CTRL_DIVZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_func = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        flags_clr = 1'b0;
    logic [15:0] alu_a, alu_b;
    logic [4:0]  alu_func;
    logic [5:0]  alu_flagsin;
    logic [15:0] alu_y;
    logic [5:0]  alu_flagsout;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_y;
    logic        rsp_err;
    logic [5:0]  flags_q;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_on  = 1'b0;

    alu16_ctrl #(.MULDIV_WAIT(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_func(req_func), .req_a(req_a), .req_b(req_b),
        .flags_clr(flags_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_flagsin(alu_flagsin),
        .alu_y(alu_y), .alu_flagsout(alu_flagsout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_err(rsp_err), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {flags_out, y}.
    function automatic logic [21:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [4:0] f, input logic [5:0] fin);
        logic [16:0] s;
        logic [31:0] p;
        logic [15:0] y;
        logic [5:0]  fo;
        int unsigned n;
        fo = '0;
        y  = '0;
        n  = int'(b[3:0]);
        case (f)
            5'd0: begin s = {1'b0, a} + {1'b0, b} + {16'b0, fin[3]}; y = s[15:0]; fo[4] = s[16]; end
            5'd1: begin s = {1'b0, a} - {1'b0, b} - {16'b0, fin[3]}; y = s[15:0]; fo[4] = s[16]; end
            5'd2: begin p = a * b; y = p[15:0]; fo[4] = |p[31:16]; end
            5'd3: begin if (b == 0) begin y = 16'hFFFF; fo[4] = 1'b1; end else y = a / b; end
            5'd4: begin if (b == 0) begin y = a; fo[4] = 1'b1; end else y = a % b; end
            5'd5: y = ~b;
            5'd6: y = a | b;
            5'd7: y = a & b;
            5'd8: y = a | ~b;
            5'd9: y = a & ~b;
            5'd10: y = a ^ b;
            5'd11: y = ~(a ^ b);
            5'd12: for (int i = 0; i < 16; i++) y[i] = a[15-i];
            5'd13: begin y = a << n; fo[3] = (n == 0) ? 1'b0 : a[16-n]; end
            5'd14: begin y = a >> n; fo[3] = (n == 0) ? 1'b0 : a[n-1]; end
            5'd15: begin y = $signed(a) >>> n; fo[3] = (n == 0) ? 1'b0 : a[n-1]; end
            5'd17: begin y = a - b; fo[1] = (a > b); fo[0] = (a < b); end
            default: y = '0;
        endcase
        fo[5] = (y == 0);
        fo[2] = ^y;
        return {fo, y};
    endfunction

    function automatic logic [5:0] fmask(input logic [4:0] f);
        if (f <= 3) return 6'b010000;
        if (f >= 13 && f <= 15) return 6'b001000;
        if (f == 17) return 6'b100111;
        return 6'b000000;
    endfunction

    always_comb {alu_flagsout, alu_y} = alu_ref(alu_a, alu_b, alu_func, alu_flagsin);

    // Reference model: one outstanding transaction, countdown to capture.
    logic        m_busy, m_valid, m_err;
    int          m_left;
    logic [15:0] m_a, m_b, m_y;
    logic [4:0]  m_func;
    logic [5:0]  m_flags;
    logic        pre_valid, pre_busy;
    logic [21:0] r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_err = 0; m_left = 0;
            m_a = '0; m_b = '0; m_y = '0; m_func = 5'd16; m_flags = '0;
        end else begin
            pre_valid = m_valid;
            pre_busy  = m_busy;
            if (m_busy && !m_valid) begin
                if (m_left == 1) begin
                    r       = alu_ref(m_a, m_b, m_func, m_flags);
                    m_y     = r[15:0];
                    m_err   = 1'b0;
                    m_flags = (m_flags & ~fmask(m_func)) | (r[21:16] & fmask(m_func));
                    m_valid = 1'b1;
                end else begin
                    m_left--;
                end
            end
            if (flags_clr) m_flags = '0;
            if (pre_valid && rsp_ready) begin
                m_busy  = 1'b0;
                m_valid = 1'b0;
            end
            if (!pre_busy && req_valid) begin
                m_busy = 1'b1;
                m_a = req_a; m_b = req_b; m_func = req_func;
                if (req_func > 17) begin
                    m_y = '0; m_err = 1'b1; m_valid = 1'b1;
                end else if (TRAP && (req_func == 3 || req_func == 4) && req_b == 0) begin
                    m_y = 16'hFFFF; m_err = 1'b1; m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                    m_left  = (req_func >= 2 && req_func <= 4) ? int'(W) : 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (mon_on) begin
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("rsp_y", 32'(rsp_y), 32'(m_y));
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
            chk("flags_q", 32'(flags_q), 32'(m_flags));
            chk("alu_flagsin", 32'(alu_flagsin), 32'(m_flags));
            chk("alu_func", 32'(alu_func), (m_busy && !m_valid) ? 32'(m_func) : 32'd16);
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
        end
    end

    // Called at posedge+1 with the DUT idle; returns after the handshake edge.
    task automatic drive_req(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b);
        req_valid = 1'b1; req_func = f; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // lat = cycle index (handshake edge = 0) at which rsp_valid is first seen.
    task automatic wait_rsp(input logic [4:0] f, output int lat, output int nf);
        lat = 1; nf = 0;
        while (!rsp_valid && lat < 60) begin
            if (alu_func == f) nf++;
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    int lat, nf;
    logic [4:0] rf;

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_func", 32'(alu_func), 32'd16);
        chk("rst_flags", 32'(flags_q), 32'd0);
        chk("rst_rsp_y", 32'(rsp_y), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        drive_req(5'd0, 16'd10000, 16'd2);
        wait_rsp(5'd0, lat, nf);
        chk("add_y", 32'(rsp_y), 32'd10002);
        chk("add_lat", 32'(lat), 32'd2);
        chk("add_flags", 32'(flags_q), 32'd0);
        take_rsp();

        drive_req(5'd1, 16'd5, 16'd7);
        wait_rsp(5'd1, lat, nf);
        chk("sub_y", 32'(rsp_y), 32'hFFFE);
        chk("sub_cf4", 32'(flags_q[4]), 32'd1);
        take_rsp();

        drive_req(5'd17, 16'h00F6, 16'h000A);
        wait_rsp(5'd17, lat, nf);
        chk("cmp_gf", 32'(flags_q[1]), 32'd1);
        chk("cmp_zf", 32'(flags_q[5]), 32'd0);
        chk("cmp_lf", 32'(flags_q[0]), 32'd0);
        chk("cmp_cf4", 32'(flags_q[4]), 32'd1);
        take_rsp();

        drive_req(5'd3, 16'd10000, 16'd2);
        wait_rsp(5'd3, lat, nf);
        chk("div_y", 32'(rsp_y), 32'd5000);
        chk("div_lat", 32'(lat), 32'(W + 1));
        chk("div_exec_cycles", 32'(nf), 32'(W));
        chk("div_flags", 32'(flags_q), 32'b000110);
        take_rsp();

        drive_req(5'd3, 16'd1234, 16'd0);
        wait_rsp(5'd3, lat, nf);
        if (TRAP) begin
            chk("div0_trap_lat", 32'(lat), 32'd1);
            chk("div0_trap_err", 32'(rsp_err), 32'd1);
            chk("div0_trap_y", 32'(rsp_y), 32'hFFFF);
            chk("div0_trap_flags", 32'(flags_q), 32'b000110);
        end else begin
            chk("div0_lat", 32'(lat), 32'(W + 1));
            chk("div0_err", 32'(rsp_err), 32'd0);
            chk("div0_y", 32'(rsp_y), 32'hFFFF);
            chk("div0_flags", 32'(flags_q), 32'b010110);
        end
        take_rsp();

        drive_req(5'd20, 16'h5555, 16'h1111);
        wait_rsp(5'd20, lat, nf);
        chk("ill_lat", 32'(lat), 32'd1);
        chk("ill_err", 32'(rsp_err), 32'd1);
        chk("ill_y", 32'(rsp_y), 32'd0);
        take_rsp();

        drive_req(5'd13, 16'h8000, 16'd1);
        wait_rsp(5'd13, lat, nf);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("lsl_hold_valid", 32'(rsp_valid), 32'd1);
            chk("lsl_hold_y", 32'(rsp_y), 32'd0);
            chk("lsl_hold_ready", 32'(req_ready), 32'd0);
            chk("lsl_cf3", 32'(flags_q[3]), 32'd1);
        end
        take_rsp();
        chk("b2b_ready", 32'(req_ready), 32'd1);
        drive_req(5'd6, 16'h1234, 16'h00F0);
        chk("b2b_accept_a", 32'(alu_a), 32'h1234);
        chk("b2b_busy", 32'(req_ready), 32'd0);
        wait_rsp(5'd6, lat, nf);
        chk("b2b_y", 32'(rsp_y), 32'h12F4);
        take_rsp();

        drive_req(5'd2, 16'd300, 16'd7);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_req_ready", 32'(req_ready), 32'd1);
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_alu_func", 32'(alu_func), 32'd16);
        chk("mrst_flags", 32'(flags_q), 32'd0);
        chk("mrst_rsp_y", 32'(rsp_y), 32'd0);
        chk("mrst_rsp_err", 32'(rsp_err), 32'd0);
        chk("mrst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("mrst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        drive_req(5'd1, 16'd5, 16'd7);
        wait_rsp(5'd1, lat, nf);
        chk("pre_clr_cf4", 32'(flags_q[4]), 32'd1);
        take_rsp();
        drive_req(5'd17, 16'd3, 16'd3);
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        chk("clr_cmp_valid", 32'(rsp_valid), 32'd1);
        chk("clr_cmp_flags", 32'(flags_q), 32'd0);
        take_rsp();

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 1) == 1);
            rf        = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(18, 31))
                                                    : 5'($urandom_range(0, 17));
            req_func  = rf;
            req_a     = 16'($urandom);
            req_b     = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            flags_clr = ($urandom_range(0, 19) == 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        flags_clr = 1'b0;
        rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
